// File: rtl/abus_initiator.sv
// Cartridge A-bus initiator: turns single Avalon-MM slave transfers into timed
// A-bus read/write cycles (setup, strobe with /WAIT extension, hold, done).
module abus_initiator #(
    parameter int SETUP_CYCLES   = 2,
    parameter int STROBE_CYCLES  = 4,
    parameter int HOLD_CYCLES    = 1,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic        clk_clk,
    input  logic        reset_reset_n,
    input  logic [26:0] avs_address,
    input  logic        avs_read,
    input  logic        avs_write,
    input  logic [1:0]  avs_byteenable,
    input  logic [15:0] avs_writedata,
    output logic [15:0] avs_readdata,
    output logic        avs_waitrequest,
    output logic [24:0] abus_address,
    output logic [2:0]  abus_chipselect_n,
    output logic        abus_read_n,
    output logic [1:0]  abus_writebyteenable_n,
    output logic [15:0] abus_data_out,
    output logic        abus_data_oe,
    input  logic [15:0] abus_data_in,
    input  logic        abus_wait_n,
    input  logic        status_clear,
    output logic        timeout_flag,
    output logic [2:0]  dbg_state
);

    // Handshake: avs_read/avs_write are sampled only while the FSM is IDLE; the
    // transfer completes on the single cycle in which avs_waitrequest is 0 (DONE),
    // and avs_readdata is valid in that cycle for reads.

    localparam int PMAX_SW = (SETUP_CYCLES > STROBE_CYCLES) ? SETUP_CYCLES : STROBE_CYCLES;
    localparam int PMAX    = (PMAX_SW > HOLD_CYCLES) ? PMAX_SW : HOLD_CYCLES;
    localparam int PW      = (PMAX > 1) ? $clog2(PMAX) : 1;
    localparam int TW      = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [PW-1:0] SETUP_LAST  = PW'(SETUP_CYCLES - 1);
    localparam logic [PW-1:0] STROBE_LAST = PW'(STROBE_CYCLES - 1);
    localparam logic [PW-1:0] HOLD_LAST   = PW'(HOLD_CYCLES - 1);
    localparam logic [TW-1:0] EXT_LIMIT   = TW'(TIMEOUT_CYCLES);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SETUP  = 3'd1,
        STROBE = 3'd2,
        HOLD   = 3'd3,
        DONE   = 3'd4
    } state_t;

    state_t        state;
    logic [PW-1:0] phase_cnt;
    logic [TW-1:0] ext_cnt;
    logic          is_read;
    logic [1:0]    be_q;
    logic          wait_meta;
    logic          wait_s;

    assign dbg_state = state;

    function automatic logic [2:0] cs_n_of(input logic [1:0] sel);
        logic [2:0] cs_n;
        case (sel)
            2'b00:   cs_n = 3'b110;
            2'b01:   cs_n = 3'b101;
            2'b10:   cs_n = 3'b011;
            default: cs_n = 3'b111;
        endcase
        return cs_n;
    endfunction

    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n) begin
            state                  <= IDLE;
            phase_cnt              <= '0;
            ext_cnt                <= '0;
            is_read                <= 1'b0;
            be_q                   <= 2'b00;
            wait_meta              <= 1'b1;
            wait_s                 <= 1'b1;
            avs_readdata           <= 16'h0000;
            avs_waitrequest        <= 1'b1;
            abus_address           <= 25'd0;
            abus_chipselect_n      <= 3'b111;
            abus_read_n            <= 1'b1;
            abus_writebyteenable_n <= 2'b11;
            abus_data_out          <= 16'h0000;
            abus_data_oe           <= 1'b0;
            timeout_flag           <= 1'b0;
        end else begin
            wait_meta <= abus_wait_n;
            wait_s    <= wait_meta;

            // A timeout set later in this block overrides the clear.
            if (status_clear) begin
                timeout_flag <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (avs_read || avs_write) begin
                        is_read   <= avs_read;
                        be_q      <= avs_byteenable;
                        phase_cnt <= '0;
                        ext_cnt   <= '0;
                        if (avs_address[26:25] == 2'b11 ||
                            (!avs_read && avs_byteenable == 2'b00)) begin
                            // Nothing to put on the bus: complete immediately.
                            state           <= DONE;
                            avs_waitrequest <= 1'b0;
                            if (avs_read) begin
                                avs_readdata <= 16'hFFFF;
                            end
                        end else begin
                            state             <= SETUP;
                            abus_address      <= avs_address[24:0];
                            abus_chipselect_n <= cs_n_of(avs_address[26:25]);
                            if (!avs_read) begin
                                abus_data_out <= avs_writedata;
                                abus_data_oe  <= 1'b1;
                            end
                        end
                    end
                end

                SETUP: begin
                    if (phase_cnt == SETUP_LAST) begin
                        state     <= STROBE;
                        phase_cnt <= '0;
                        if (is_read) begin
                            abus_read_n <= 1'b0;
                        end else begin
                            abus_writebyteenable_n <= ~be_q;
                        end
                    end else begin
                        phase_cnt <= phase_cnt + 1'b1;
                    end
                end

                STROBE: begin
                    if (phase_cnt != STROBE_LAST) begin
                        phase_cnt <= phase_cnt + 1'b1;
                    end else if (wait_s || ext_cnt == EXT_LIMIT) begin
                        // Last strobe cycle: either the responder released /WAIT
                        // or the extension budget is spent.
                        state                  <= HOLD;
                        phase_cnt              <= '0;
                        abus_read_n            <= 1'b1;
                        abus_writebyteenable_n <= 2'b11;
                        if (is_read) begin
                            avs_readdata <= wait_s ? abus_data_in : 16'hFFFF;
                        end
                        if (!wait_s) begin
                            timeout_flag <= 1'b1;
                        end
                    end else begin
                        ext_cnt <= ext_cnt + 1'b1;
                    end
                end

                HOLD: begin
                    if (phase_cnt == HOLD_LAST) begin
                        state             <= DONE;
                        abus_chipselect_n <= 3'b111;
                        abus_data_oe      <= 1'b0;
                        avs_waitrequest   <= 1'b0;
                    end else begin
                        phase_cnt <= phase_cnt + 1'b1;
                    end
                end

                DONE: begin
                    state           <= IDLE;
                    avs_waitrequest <= 1'b1;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_abus_initiator.sv
// Bench for abus_initiator: directed and random transfers compared cycle by
// cycle against a timing model derived from the bus cycle rules.
module tb_abus_initiator;

    localparam int S = 2;
    localparam int W = 4;
    localparam int H = 1;
    localparam int T = 8;

    logic        clk_clk;
    logic        reset_reset_n;
    logic [26:0] avs_address;
    logic        avs_read;
    logic        avs_write;
    logic [1:0]  avs_byteenable;
    logic [15:0] avs_writedata;
    logic [15:0] avs_readdata;
    logic        avs_waitrequest;
    logic [24:0] abus_address;
    logic [2:0]  abus_chipselect_n;
    logic        abus_read_n;
    logic [1:0]  abus_writebyteenable_n;
    logic [15:0] abus_data_out;
    logic        abus_data_oe;
    logic [15:0] abus_data_in;
    logic        abus_wait_n;
    logic        status_clear;
    logic        timeout_flag;
    logic [2:0]  dbg_state;

    int n_checks = 0;
    int n_pass   = 0;

    logic        exp_flag  = 1'b0;
    logic [15:0] exp_rdata = 16'h0000;

    abus_initiator #(
        .SETUP_CYCLES(S), .STROBE_CYCLES(W), .HOLD_CYCLES(H), .TIMEOUT_CYCLES(T)
    ) dut (
        .clk_clk(clk_clk),
        .reset_reset_n(reset_reset_n),
        .avs_address(avs_address),
        .avs_read(avs_read),
        .avs_write(avs_write),
        .avs_byteenable(avs_byteenable),
        .avs_writedata(avs_writedata),
        .avs_readdata(avs_readdata),
        .avs_waitrequest(avs_waitrequest),
        .abus_address(abus_address),
        .abus_chipselect_n(abus_chipselect_n),
        .abus_read_n(abus_read_n),
        .abus_writebyteenable_n(abus_writebyteenable_n),
        .abus_data_out(abus_data_out),
        .abus_data_oe(abus_data_oe),
        .abus_data_in(abus_data_in),
        .abus_wait_n(abus_wait_n),
        .status_clear(status_clear),
        .timeout_flag(timeout_flag),
        .dbg_state(dbg_state)
    );

    initial begin
        clk_clk = 1'b0;
        forever #5 clk_clk = ~clk_clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // {cs_n, read_n, wbe_n, oe, waitrequest, timeout_flag, readdata}
    function automatic logic [24:0] obs();
        return {abus_chipselect_n, abus_read_n, abus_writebyteenable_n, abus_data_oe,
                avs_waitrequest, timeout_flag, avs_readdata};
    endfunction

    task automatic chk(input string tag, input int cyc, input logic [31:0] got,
                       input logic [31:0] exp);
        n_checks++;
        assert (got === exp) n_pass = n_pass + 1;
        else $error("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
    endtask

    task automatic drive_idle();
        avs_read       = 1'b0;
        avs_write      = 1'b0;
        avs_address    = 27'd0;
        avs_byteenable = 2'b00;
        avs_writedata  = 16'h0000;
        abus_data_in   = 16'h0000;
        abus_wait_n    = 1'b1;
        status_clear   = 1'b0;
    endtask

    // One transfer starting at cycle 0 (called just after a rising edge).
    // wait_n is low for cycles wlo_s..wlo_e inclusive.
    task automatic do_xfer(input string tag, input logic rd, input logic wr,
                           input logic [1:0] sel, input logic [24:0] addr,
                           input logic [1:0] be, input logic [15:0] wdata,
                           input int wlo_s, input int wlo_e, input logic clr,
                           input logic fixed_din);
        logic [15:0] din [64];
        logic        wn  [64];
        int          last, done_c, rd_from, act_end;
        logic        is_rd, idle_path, tmo, got_done, cs_on, stb_on;
        logic [15:0] rd_new;
        logic [24:0] exp_v;

        is_rd = rd;
        for (int c = 0; c < 64; c++) begin
            wn[c]  = !(c >= wlo_s && c <= wlo_e);
            din[c] = fixed_din ? 16'hA55A : 16'($urandom);
        end
        idle_path = (sel == 2'b11) || (!is_rd && be == 2'b00);
        if (idle_path) begin
            last    = 0;
            act_end = 0;
            done_c  = 1;
            tmo     = 1'b0;
            rd_new  = is_rd ? 16'hFFFF : exp_rdata;
            rd_from = 1;
        end else begin
            // The synchronized wait seen in cycle c is wait_n from cycle c-2.
            last = S + W;
            while (last < S + W + T && !wn[last - 2]) last++;
            tmo     = !wn[last - 2];
            act_end = last + H;
            done_c  = last + H + 1;
            rd_new  = !is_rd ? exp_rdata : (tmo ? 16'hFFFF : din[last]);
            rd_from = last + 1;
        end

        got_done = 1'b0;
        for (int c = 0; c < 48 && !got_done; c++) begin
            avs_read       = rd;
            avs_write      = wr;
            avs_address    = {sel, addr};
            avs_byteenable = be;
            avs_writedata  = wdata;
            abus_wait_n    = wn[c];
            abus_data_in   = din[c];
            status_clear   = clr;
            @(negedge clk_clk);
            cs_on  = !idle_path && c >= 1 && c <= act_end;
            stb_on = !idle_path && c >= S + 1 && c <= last;
            exp_v = {cs_on ? ~(3'b001 << sel) : 3'b111,
                     !(is_rd && stb_on),
                     (!is_rd && stb_on) ? ~be : 2'b11,
                     !is_rd && cs_on,
                     c != done_c,
                     exp_flag,
                     (c >= rd_from) ? rd_new : exp_rdata};
            chk({tag, "_bus"}, c, 32'(obs()), 32'(exp_v));
            if (cs_on) chk({tag, "_addr"}, c, 32'(abus_address), 32'(addr));
            if (cs_on && !is_rd) chk({tag, "_wdata"}, c, 32'(abus_data_out), 32'(wdata));
            got_done = (avs_waitrequest == 1'b0);
            if (tmo && c == last) exp_flag = 1'b1;
            else if (clr)         exp_flag = 1'b0;
            @(posedge clk_clk);
            #1;
        end
        chk({tag, "_done_seen"}, done_c, 32'(got_done), 32'd1);
        exp_rdata = rd_new;

        drive_idle();
        @(negedge clk_clk);
        chk({tag, "_after"}, done_c + 1, 32'(obs()),
            32'({3'b111, 1'b1, 2'b11, 1'b0, 1'b1, exp_flag, exp_rdata}));
        @(posedge clk_clk);
        #1;
    endtask

    initial begin
        drive_idle();
        reset_reset_n = 1'b0;
        repeat (3) @(posedge clk_clk);
        @(negedge clk_clk);
        chk("reset_outs", 0, 32'(obs()), 32'({3'b111, 1'b1, 2'b11, 1'b0, 1'b1, 1'b0, 16'h0000}));
        chk("reset_addr", 0, 32'(abus_address), 32'd0);
        chk("reset_dout", 0, 32'(abus_data_out), 32'd0);
        @(posedge clk_clk);
        #1;
        reset_reset_n = 1'b1;
        @(posedge clk_clk);
        #1;

        do_xfer("rd_basic", 1'b1, 1'b0, 2'b00, 25'h0000100, 2'b11, 16'h0000, -1, -1, 1'b0, 1'b1);
        do_xfer("wr_cs1",   1'b0, 1'b1, 2'b01, 25'h0ABCDE0, 2'b10, 16'h1234, -1, -1, 1'b0, 1'b0);
        do_xfer("rd_wait",  1'b1, 1'b0, 2'b10, 25'h1FFFFFF, 2'b11, 16'h0000, 4, 10, 1'b0, 1'b0);
        do_xfer("rd_edge",  1'b1, 1'b0, 2'b00, 25'h0000002, 2'b01, 16'h0000, 4, 11, 1'b0, 1'b0);
        do_xfer("rd_tmo",   1'b1, 1'b0, 2'b01, 25'h0001000, 2'b11, 16'h0000, 4, 99, 1'b0, 1'b0);

        status_clear = 1'b1;
        @(negedge clk_clk);
        chk("flag_before_clr", 0, 32'(timeout_flag), 32'(exp_flag));
        @(posedge clk_clk);
        #1;
        status_clear = 1'b0;
        exp_flag = 1'b0;
        @(negedge clk_clk);
        chk("flag_cleared", 1, 32'(timeout_flag), 32'd0);
        @(posedge clk_clk);
        #1;

        do_xfer("wr_tmo_clr", 1'b0, 1'b1, 2'b10, 25'h0123456, 2'b11, 16'hBEEF, 4, 12, 1'b1, 1'b0);
        do_xfer("rd_sel3",    1'b1, 1'b0, 2'b11, 25'h0000040, 2'b11, 16'h0000, -1, -1, 1'b0, 1'b0);
        do_xfer("wr_be0",     1'b0, 1'b1, 2'b00, 25'h0000044, 2'b00, 16'h5555, -1, -1, 1'b0, 1'b0);
        do_xfer("rdwr_both",  1'b1, 1'b1, 2'b01, 25'h0000888, 2'b01, 16'h7777, -1, -1, 1'b0, 1'b0);

        // Reset in the middle of a write strobe.
        for (int c = 0; c < 5; c++) begin
            avs_write      = 1'b1;
            avs_address    = {2'b01, 25'h0000500};
            avs_byteenable = 2'b11;
            avs_writedata  = 16'hC0DE;
            if (c == 4) reset_reset_n = 1'b0;
            @(negedge clk_clk);
            if (c == 4) chk("rst_mid_strobe", c, 32'(abus_writebyteenable_n), 32'(2'b00));
            @(posedge clk_clk);
            #1;
        end
        drive_idle();
        @(negedge clk_clk);
        chk("rst_mid_outs", 5, 32'(obs()), 32'({3'b111, 1'b1, 2'b11, 1'b0, 1'b1, 1'b0, 16'h0000}));
        chk("rst_mid_addr", 5, 32'(abus_address), 32'd0);
        chk("rst_mid_dout", 5, 32'(abus_data_out), 32'd0);
        exp_flag  = 1'b0;
        exp_rdata = 16'h0000;
        @(posedge clk_clk);
        #1;
        reset_reset_n = 1'b1;
        @(posedge clk_clk);
        #1;
        do_xfer("rd_after_rst", 1'b1, 1'b0, 2'b10, 25'h0000600, 2'b11, 16'h0000, -1, -1, 1'b0, 1'b0);

        for (int i = 0; i < 24; i++) begin
            logic [1:0]  sel, be;
            logic        rd, wr, clr;
            int          kind, ws, we;
            sel  = 2'($urandom_range(0, 3));
            be   = 2'($urandom_range(0, 3));
            kind = $urandom_range(0, 3);
            rd   = (kind == 0 || kind == 2);
            wr   = (kind != 0);
            clr  = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 2) == 0) begin
                ws = -1;
                we = -1;
            end else begin
                ws = $urandom_range(0, 8);
                we = ws + $urandom_range(0, 12);
            end
            do_xfer("rand", rd, wr, sel, 25'($urandom), be, 16'($urandom), ws, we, clr, 1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
